// File: rtl/result_demux_pkg.sv
// Shared types and default sizes for the result demultiplexer.
// The optional per-channel statistics are enabled by defining RESULT_DEMUX_STATS_EN.
package result_demux_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned CNT_W      = 16;

  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

  // Next pointer value; pointer width equals log2(depth) so the add wraps naturally.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input int unsigned ptr_w);
    logic [7:0] nxt;
    logic [7:0] mask;
    nxt  = ptr + 8'd1;
    mask = 8'((9'd1 << ptr_w) - 9'd1);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel circular FIFO with occupancy count; head word reads as zero when empty.
module demux_chan_fifo
  import result_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q,  count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Head word is masked so downstream never sees stale storage.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = PTR_W'(ptr_inc(8'(wr_ptr_q), PTR_W));
    end
    if (pop_ok) begin
      rd_ptr_d = PTR_W'(ptr_inc(8'(rd_ptr_q), PTR_W));
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observable while count is non-zero.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/result_demux.sv
// Routes one result stream into two independently drained channel FIFOs.
// Define RESULT_DEMUX_STATS_EN to add the A_Count/B_Count accepted-word counters.
module result_demux
  import result_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Sel,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [DATA_W-1:0] A_Data,
  output logic              A_Valid,
  input  logic              A_Ready,
  output logic [DATA_W-1:0] B_Data,
  output logic              B_Valid,
  input  logic              B_Ready
`ifdef RESULT_DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  A_Count,
  output logic [CNT_W-1:0]  B_Count
`endif
);

  chan_e sel;
  logic  full_a, full_b;
  logic  empty_a, empty_b;
  logic  push_a, push_b;

  assign sel = chan_e'(In_Sel);

  // Acceptance depends only on the selected channel's occupancy, never on a same-cycle pop.
  assign In_Ready = (sel == CH_B) ? ~full_b : ~full_a;
  assign push_a   = In_Valid & In_Ready & (sel == CH_A);
  assign push_b   = In_Valid & In_Ready & (sel == CH_B);

  assign A_Valid = ~empty_a;
  assign B_Valid = ~empty_b;

  demux_chan_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_a (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push_a),
    .push_data (In_Data),
    .pop       (A_Ready),
    .full      (full_a),
    .empty     (empty_a),
    .head_data (A_Data)
  );

  demux_chan_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_b (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push_b),
    .push_data (In_Data),
    .pop       (B_Ready),
    .full      (full_b),
    .empty     (empty_b),
    .head_data (B_Data)
  );

`ifdef RESULT_DEMUX_STATS_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  // Free-running accepted-push counters; wrap at the top of their range.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (push_a) a_cnt_d = a_cnt_q + CNT_W'(1);
    if (push_b) b_cnt_d = b_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign A_Count = a_cnt_q;
  assign B_Count = b_cnt_q;
`endif

endmodule

// File: tb/tb_result_demux.sv
// Directed self-checking bench for result_demux (stats checks when RESULT_DEMUX_STATS_EN is defined).
module tb_result_demux;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] In_Data;
  logic        In_Sel;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] A_Data;
  logic        A_Valid;
  logic        A_Ready;
  logic [31:0] B_Data;
  logic        B_Valid;
  logic        B_Ready;
`ifdef RESULT_DEMUX_STATS_EN
  logic [15:0] A_Count;
  logic [15:0] B_Count;
`endif

  int checks = 0;
  int errors = 0;

  result_demux dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .In_Data  (In_Data),
    .In_Sel   (In_Sel),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .A_Data   (A_Data),
    .A_Valid  (A_Valid),
    .A_Ready  (A_Ready),
    .B_Data   (B_Data),
    .B_Valid  (B_Valid),
    .B_Ready  (B_Ready)
`ifdef RESULT_DEMUX_STATS_EN
    ,
    .A_Count  (A_Count),
    .B_Count  (B_Count)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic sel, input logic [31:0] d);
    In_Sel   = sel;
    In_Data  = d;
    In_Valid = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; In_Data = '0; In_Sel = 1'b0; In_Valid = 1'b0;
    A_Ready = 1'b0; B_Ready = 1'b0;
    #1;
    chk("rst_a_valid", 32'(A_Valid), 32'd0);
    chk("rst_b_valid", 32'(B_Valid), 32'd0);
    chk("rst_a_data", A_Data, 32'd0);
    chk("rst_b_data", B_Data, 32'd0);
    chk("rst_in_ready", 32'(In_Ready), 32'd1);
    step(); step();
    Reset = 1'b0;
    step();

    // 1: single word to A
    push(1'b0, 32'h11);
    step();
    In_Valid = 1'b0;
    chk("t1_a_valid", 32'(A_Valid), 32'd1);
    chk("t1_a_data", A_Data, 32'h11);
    chk("t1_b_valid", 32'(B_Valid), 32'd0);
    A_Ready = 1'b1;
    step();
    A_Ready = 1'b0;
    chk("t1_a_drained", 32'(A_Valid), 32'd0);

    // 2: fill B, check per-channel ready, then drain in order
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'hB0 + 32'(i));
      chk("t2_ready_fill", 32'(In_Ready), 32'd1);
      step();
    end
    chk("t2_ready_b_full", 32'(In_Ready), 32'd0);
    In_Sel = 1'b0;
    #1;
    chk("t2_ready_a_free", 32'(In_Ready), 32'd1);
    In_Valid = 1'b0;
    B_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_b_valid", 32'(B_Valid), 32'd1);
      chk("t2_b_data", B_Data, 32'hB0 + 32'(i));
      step();
    end
    chk("t2_b_empty", 32'(B_Valid), 32'd0);
    chk("t2_b_data0", B_Data, 32'd0);

    // 3: alternating routes with both consumers ready
    A_Ready = 1'b1;
    push(1'b0, 32'hA0); step();
    chk("t3_a0_valid", 32'(A_Valid), 32'd1);
    chk("t3_a0_data", A_Data, 32'hA0);
    chk("t3_a0_b_idle", 32'(B_Valid), 32'd0);
    push(1'b1, 32'hB0); step();
    chk("t3_b0_valid", 32'(B_Valid), 32'd1);
    chk("t3_b0_data", B_Data, 32'hB0);
    chk("t3_b0_a_idle", 32'(A_Valid), 32'd0);
    push(1'b0, 32'hA1); step();
    chk("t3_a1_data", A_Data, 32'hA1);
    chk("t3_a1_b_idle", 32'(B_Valid), 32'd0);
    push(1'b1, 32'hB1); step();
    chk("t3_b1_data", B_Data, 32'hB1);
    chk("t3_b1_a_idle", 32'(A_Valid), 32'd0);
    In_Valid = 1'b0; step();
    chk("t3_a_end", 32'(A_Valid), 32'd0);
    chk("t3_b_end", 32'(B_Valid), 32'd0);

    // 4: full channel refuses even while its consumer pops
    A_Ready = 1'b0; B_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'hC0 + 32'(i)); step();
    end
    push(1'b0, 32'hD0);
    A_Ready = 1'b1;
    #1;
    chk("t4_full_ready", 32'(In_Ready), 32'd0);
    step();
    chk("t4_ready_after_pop", 32'(In_Ready), 32'd1);
    chk("t4_head_c1", A_Data, 32'hC1);
    A_Ready = 1'b0;
    step();
    In_Valid = 1'b0;
    chk("t4_full_again", 32'(In_Ready), 32'd0);
    A_Ready = 1'b1;
    chk("t4_drain0", A_Data, 32'hC1); step();
    chk("t4_drain1", A_Data, 32'hC2); step();
    chk("t4_drain2", A_Data, 32'hC3); step();
    chk("t4_drain3", A_Data, 32'hD0); step();
    chk("t4_empty", 32'(A_Valid), 32'd0);

    // 5: asynchronous reset with both channels holding words
    A_Ready = 1'b0; B_Ready = 1'b0;
    push(1'b0, 32'h51); step();
    push(1'b0, 32'h52); step();
    push(1'b1, 32'h61); step();
    push(1'b1, 32'h62); step();
    In_Valid = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    chk("t5_a_valid", 32'(A_Valid), 32'd0);
    chk("t5_b_valid", 32'(B_Valid), 32'd0);
    chk("t5_a_data", A_Data, 32'd0);
    chk("t5_b_data", B_Data, 32'd0);
    chk("t5_in_ready", 32'(In_Ready), 32'd1);
    step();
    Reset = 1'b0;
    step();
    chk("t5_a_stale", 32'(A_Valid), 32'd0);
    chk("t5_b_stale", 32'(B_Valid), 32'd0);
    push(1'b0, 32'hE0); step();
    In_Valid = 1'b0;
    chk("t5_fresh_data", A_Data, 32'hE0);
    A_Ready = 1'b1; step();
    chk("t5_fresh_only", 32'(A_Valid), 32'd0);

`ifdef RESULT_DEMUX_STATS_EN
    // 6: accepted-word counters and wraparound
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("t6_cnt_rst", 32'(A_Count), 32'd0);
    A_Ready = 1'b1; B_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin push(1'b0, 32'(i)); step(); end
    for (int i = 0; i < 5; i++) begin push(1'b1, 32'(i)); step(); end
    In_Valid = 1'b0; step();
    chk("t6_a_count", 32'(A_Count), 32'd3);
    chk("t6_b_count", 32'(B_Count), 32'd5);
    push(1'b0, 32'h77);
    for (int i = 0; i < 65532; i++) step();
    chk("t6_a_max", 32'(A_Count), 32'hFFFF);
    step();
    In_Valid = 1'b0;
    chk("t6_a_wrap", 32'(A_Count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
